// File: rtl/cam_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : cam_frame_writer
// Brief    : DVP RGB565 byte stream -> RGB888 raster writes into frame RAM.
// Revision : 1.0
// ============================================================================
module cam_frame_writer #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 17,
    parameter int WIDTH  = 480,
    parameter int HEIGHT = 272
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEnable,
    input  logic              iVSync,
    input  logic              iHRef,
    input  logic [7:0]        iData,
    output logic              oWrEn,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic [DATA_W-1:0] oWrData,
    output logic              oFrameDone,
    output logic              oBusy,
    output logic              oFrameErr,
    output logic [7:0]        oFrameCnt
);

    localparam int c_XW = $clog2(WIDTH + 1);
    localparam int c_YW = $clog2(HEIGHT + 1);
    localparam logic [c_XW-1:0]   c_XMAX      = c_XW'(WIDTH);
    localparam logic [c_YW-1:0]   c_YMAX      = c_YW'(HEIGHT);
    localparam logic [ADDR_W-1:0] c_LINE_STEP = ADDR_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic              r_vSync;
    logic              r_vSyncPrev;
    logic              r_hRef;
    logic              r_hRefPrev;
    logic [7:0]        r_data;
    logic [7:0]        r_hiByte;
    logic              r_phase;
    logic [c_XW-1:0]   r_x;
    logic [c_YW-1:0]   r_y;
    logic [ADDR_W-1:0] r_lineBase;

    logic        w_vsFall;
    logic        w_vsRise;
    logic        w_hrFall;
    logic        w_inRange;
    logic [15:0] w_pix;
    logic [23:0] w_rgb;

    assign w_vsFall  = r_vSyncPrev & ~r_vSync;
    assign w_vsRise  = ~r_vSyncPrev & r_vSync;
    assign w_hrFall  = r_hRefPrev & ~r_hRef;
    assign w_inRange = (r_x < c_XMAX) && (r_y < c_YMAX);
    assign w_pix     = {r_hiByte, r_data};
    // Replicate MSBs into the new LSBs so full-scale maps to 0xFF.
    assign w_rgb     = {w_pix[15:11], w_pix[15:13],
                        w_pix[10:5],  w_pix[10:9],
                        w_pix[4:0],   w_pix[4:2]};

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:    if (iEnable)  w_stateNext = S_WAIT_VS;
            S_WAIT_VS: if (w_vsFall) w_stateNext = S_CAPTURE;
            S_CAPTURE: if (w_vsRise) w_stateNext = S_DONE;
            S_DONE:    w_stateNext = iEnable ? S_WAIT_VS : S_IDLE;
            default:   w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state     <= S_IDLE;
            r_vSync     <= 1'b0;
            r_vSyncPrev <= 1'b0;
            r_hRef      <= 1'b0;
            r_hRefPrev  <= 1'b0;
            r_data      <= 8'd0;
            r_hiByte    <= 8'd0;
            r_phase     <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_lineBase  <= '0;
            oWrEn       <= 1'b0;
            oWrAddr     <= '0;
            oWrData     <= '0;
            oFrameDone  <= 1'b0;
            oBusy       <= 1'b0;
            oFrameErr   <= 1'b0;
            oFrameCnt   <= 8'd0;
        end else begin
            r_state     <= w_stateNext;
            r_vSync     <= iVSync;
            r_vSyncPrev <= r_vSync;
            r_hRef      <= iHRef;
            r_hRefPrev  <= r_hRef;
            r_data      <= iData;
            oWrEn       <= 1'b0;
            oFrameDone  <= (r_state == S_DONE);
            oBusy       <= (r_state == S_WAIT_VS) || (r_state == S_CAPTURE);

            if (r_state == S_DONE) begin
                oFrameCnt <= oFrameCnt + 8'd1;
                // y is checked here so a last-line HREF fall coincident with VSYNC still counts.
                if (r_y < c_YMAX) oFrameErr <= 1'b1;
            end

            if (r_state == S_WAIT_VS && w_vsFall) begin
                r_x        <= '0;
                r_y        <= '0;
                r_lineBase <= '0;
                r_phase    <= 1'b0;
                oFrameErr  <= 1'b0;
            end

            if (r_state == S_CAPTURE) begin
                if (r_hRef) begin
                    if (!r_phase) begin
                        r_hiByte <= r_data;
                        r_phase  <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (w_inRange) begin
                            oWrEn   <= 1'b1;
                            oWrAddr <= r_lineBase + ADDR_W'(r_x);
                            oWrData <= DATA_W'(w_rgb);
                        end else begin
                            oFrameErr <= 1'b1;
                        end
                        if (r_x != c_XMAX) r_x <= r_x + c_XW'(1);
                    end
                end else if (w_hrFall) begin
                    if (r_phase || (r_y < c_YMAX && r_x != c_XMAX)) oFrameErr <= 1'b1;
                    r_x     <= '0;
                    r_phase <= 1'b0;
                    if (r_y < c_YMAX) begin
                        r_y        <= r_y + c_YW'(1);
                        r_lineBase <= r_lineBase + c_LINE_STEP;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_frame_writer
// Brief    : Scoreboard bench for cam_frame_writer on a reduced 16x8 raster.
// Revision : 1.0
// ============================================================================
module tb_cam_frame_writer;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int AW = 17;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iEnable = 1'b0;
    logic          iVSync = 1'b1;
    logic          iHRef = 1'b0;
    logic [7:0]    iData = 8'd0;
    logic          oWrEn;
    logic [AW-1:0] oWrAddr;
    logic [23:0]   oWrData;
    logic          oFrameDone;
    logic          oBusy;
    logic          oFrameErr;
    logic [7:0]    oFrameCnt;

    cam_frame_writer #(.DATA_W(24), .ADDR_W(AW), .WIDTH(W), .HEIGHT(H)) dut (
        .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iVSync(iVSync),
        .iHRef(iHRef), .iData(iData), .oWrEn(oWrEn), .oWrAddr(oWrAddr),
        .oWrData(oWrData), .oFrameDone(oFrameDone), .oBusy(oBusy),
        .oFrameErr(oFrameErr), .oFrameCnt(oFrameCnt)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } exp_t;

    exp_t          expQ[$];
    exp_t          e;
    int            errors = 0;
    int            checks = 0;
    int            doneCount = 0;
    logic [7:0]    expCnt = 8'd0;
    logic [AW-1:0] lastA = '0;
    logic [23:0]   lastD = '0;

    function automatic logic [23:0] expand(input logic [15:0] px);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = px[15:11];
        g6 = px[10:5];
        b5 = px[4:0];
        return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
    endfunction

    function automatic logic [15:0] pixVal(input int x, input int y, input int mode);
        logic [15:0] tbl [3];
        tbl = '{16'hF800, 16'h07E0, 16'h0841};
        if (mode == 1) return tbl[x % 3];
        return 16'(x + y);
    endfunction

    function automatic logic [23:0] expData(input int x, input int y, input int mode);
        logic [23:0] tbl [3];
        tbl = '{24'hFF0000, 24'h00FF00, 24'h080808};
        if (mode == 1) return tbl[x % 3];
        return expand(16'(x + y));
    endfunction

    // Write scoreboard and output-hold monitor
    always @(negedge iClk) begin
        if (iRst) begin
            lastA = '0;
            lastD = '0;
        end else begin
            if (oFrameDone) doneCount++;
            checks++;
            if (oWrEn) begin
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h required=no write", oWrAddr, oWrData);
                end else begin
                    e = expQ.pop_front();
                    if (oWrAddr !== e.addr || oWrData !== e.data) begin
                        errors++;
                        $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                                 oWrAddr, oWrData, e.addr, e.data);
                    end
                end
                lastA = oWrAddr;
                lastD = oWrData;
            end else if (oWrAddr !== lastA || oWrData !== lastD) begin
                errors++;
                $display("FAIL hold addr=%0d data=%h required addr=%0d data=%h",
                         oWrAddr, oWrData, lastA, lastD);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic vs, input logic hr, input logic [7:0] d);
        @(posedge iClk);
        #1;
        iVSync = vs;
        iHRef  = hr;
        iData  = d;
    endtask

    task automatic sendFrame(input string tag, input int nx, input int ny, input int shortLine,
                             input int mode, input bit capture, input bit expErr,
                             input int dropAt, input int rstAt);
        bit         cap;
        int         p;
        int         doneBefore;
        logic [3:0] win;
        cap = capture;
        p = 0;
        doneBefore = doneCount;
        repeat (4) drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b0, 8'd0);
        repeat (2) drive(1'b0, 1'b0, 8'd0);
        for (int y = 0; y < ny; y++) begin
            int nb;
            nb = (y == shortLine) ? 2 * nx - 1 : 2 * nx;
            for (int b = 0; b < nb; b++) begin
                int          x;
                logic [15:0] px;
                x  = b / 2;
                px = pixVal(x, y, mode);
                if (b % 2 == 0) begin
                    if (p == dropAt) iEnable = 1'b0;
                    if (p == rstAt) begin
                        @(posedge iClk);
                        #1;
                        iRst = 1'b1;
                        #1;
                        checks++;
                        if ({oWrEn, oWrAddr, oWrData, oFrameDone, oBusy, oFrameErr, oFrameCnt} !== '0) begin
                            errors++;
                            $display("FAIL %s async_reset outputs wrEn=%b addr=%0d data=%h done=%b busy=%b err=%b cnt=%0d required all 0",
                                     tag, oWrEn, oWrAddr, oWrData, oFrameDone, oBusy, oFrameErr, oFrameCnt);
                        end
                        expQ.delete();
                        expCnt = 8'd0;
                        cap = 1'b0;
                        @(posedge iClk);
                        #1;
                        iRst = 1'b0;
                    end
                    drive(1'b0, 1'b1, px[15:8]);
                end else begin
                    drive(1'b0, 1'b1, px[7:0]);
                    if (cap && x < W && y < H)
                        expQ.push_back('{addr: AW'(y * W + x), data: expData(x, y, mode)});
                    p++;
                end
            end
            drive(1'b0, 1'b0, 8'd0);
        end
        drive(1'b0, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd0);
        @(negedge iClk);
        win = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            win = {win[2:0], oFrameDone};
        end
        checks++;
        if (win !== (cap ? 4'b0010 : 4'b0000)) begin
            errors++;
            $display("FAIL %s done_timing pulse=%b required=%b", tag, win, cap ? 4'b0010 : 4'b0000);
        end
        if (cap) expCnt = expCnt + 8'd1;
        repeat (3) drive(1'b1, 1'b0, 8'd0);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes left=%0d required=0", tag, expQ.size());
            expQ.delete();
        end
        checks++;
        if (oFrameCnt !== expCnt) begin
            errors++;
            $display("FAIL %s frame_cnt got=%0d required=%0d", tag, oFrameCnt, expCnt);
        end
        checks++;
        if (oFrameErr !== expErr) begin
            errors++;
            $display("FAIL %s frame_err got=%b required=%b", tag, oFrameErr, expErr);
        end
        checks++;
        if (doneCount - doneBefore !== (cap ? 1 : 0)) begin
            errors++;
            $display("FAIL %s done_count got=%0d required=%0d", tag, doneCount - doneBefore, cap ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge iClk);
        #1;
        checks++;
        if ({oWrEn, oWrAddr, oWrData, oFrameDone, oBusy, oFrameErr, oFrameCnt} !== '0) begin
            errors++;
            $display("FAIL reset_state wrEn=%b addr=%0d data=%h done=%b busy=%b err=%b cnt=%0d required all 0",
                     oWrEn, oWrAddr, oWrData, oFrameDone, oBusy, oFrameErr, oFrameCnt);
        end
        iRst = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 8'd0);
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got=%b required=0", oBusy);
        end
    endtask

    task automatic test_nominal();
        iEnable = 1'b1;
        repeat (3) drive(1'b1, 1'b0, 8'd0);
        checks++;
        if (oBusy !== 1'b1) begin
            errors++;
            $display("FAIL armed_busy got=%b required=1", oBusy);
        end
        sendFrame("nominal", W, H, -1, 0, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_colour();
        sendFrame("colour", W, H, -1, 1, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_oversize();
        sendFrame("oversize", W + 10, H + 4, -1, 0, 1'b1, 1'b1, -1, -1);
    endtask

    task automatic test_short_line();
        sendFrame("short_line", W, H, 5, 0, 1'b1, 1'b1, -1, -1);
    endtask

    task automatic test_short_frame();
        sendFrame("short_frame", W, H - 3, -1, 0, 1'b1, 1'b1, -1, -1);
    endtask

    task automatic test_enable();
        sendFrame("enable_drop", W, H, -1, 0, 1'b1, 1'b0, 20, -1);
        checks++;
        if (oBusy !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop busy got=%b required=0", oBusy);
        end
        sendFrame("disabled", W, H, -1, 0, 1'b0, 1'b0, -1, -1);
        iEnable = 1'b1;
        sendFrame("rearm", W, H, -1, 1, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_reset_mid();
        sendFrame("reset_mid", W, H, -1, 0, 1'b1, 1'b0, -1, 40);
        sendFrame("after_reset", W, H, -1, 0, 1'b1, 1'b0, -1, -1);
    endtask

    task automatic test_wrap();
        @(posedge iClk);
        #1;
        iRst = 1'b1;
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        expQ.delete();
        expCnt = 8'd0;
        for (int f = 0; f < 256; f++)
            sendFrame("wrap", 0, 0, -1, 0, 1'b1, 1'b1, -1, -1);
        checks++;
        if (oFrameCnt !== 8'd0) begin
            errors++;
            $display("FAIL wrap_cnt got=%0d required=0", oFrameCnt);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_colour();
        test_oversize();
        test_short_line();
        test_short_frame();
        test_enable();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
